prog_loader: RTL and testbench

- Instruction-memory writer: accepts a byte stream (valid/ready) of program image, assembles little-endian ILEN-bit words, and drives the inst_mem write port (waddr/wdata/write_en) that the fetch stage reads.
- Holds the core (busy) while loading.
- Sits between the host/debug byte source and inst_mem; fetch reads the memory only after done.

---
 rtl/prog_loader_if.sv | 37 +++
 rtl/prog_loader.sv | 149 ++++++++++++++
 tb/tb_prog_loader.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// prog_loader_if : byte-stream input and inst_mem write-port bundle of prog_loader
// Revision 1.0
// ============================================================================
interface prog_loader_if #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int CNT_W = 11
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic [XLEN-1:0]  waddr;
  logic [ILEN-1:0]  wdata;
  logic             write_en;
  logic             busy;
  logic             done;
  logic             err_overflow;
  logic [CNT_W-1:0] word_count;

  // Host / byte-source side.
  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, waddr, wdata, write_en, busy, done, err_overflow, word_count
  );

  // Loader side.
  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, waddr, wdata, write_en, busy, done, err_overflow, word_count
  );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// prog_loader : assembles a little-endian byte stream into ILEN-bit words and
//               writes them into inst_mem while holding the core busy.
// Revision 1.0
// ============================================================================
module prog_loader #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = '0,
  parameter int              MAX_WORDS = 1024,
  parameter int              CNT_W     = $clog2(MAX_WORDS) + 1
) (
  input  logic        clock,
  input  logic        reset,
  prog_loader_if.slave bus
);

  localparam int              BYTES      = ILEN / 8;
  localparam int              IDX_W      = $clog2(BYTES);
  localparam logic [XLEN-1:0] WORD_STEP  = XLEN'(BYTES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q,      state_d;
  logic [XLEN-1:0]  waddr_q,      waddr_d;
  logic [ILEN-1:0]  wdata_q,      wdata_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [IDX_W-1:0] byte_idx_q,   byte_idx_d;
  logic             err_q,        err_d;
  logic             last_seen_q,  last_seen_d;
  logic             in_ready_q;
  logic             write_en_q;
  logic             busy_q;
  logic             done_q;
  logic             xfer;

  assign xfer = bus.in_valid && in_ready_q;

  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    word_count_d = word_count_q;
    byte_idx_d   = byte_idx_q;
    err_d        = err_q;
    last_seen_d  = last_seen_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d      = S_LOAD;
          waddr_d      = BASE_ADDR;
          wdata_d      = '0;
          word_count_d = '0;
          byte_idx_d   = '0;
          err_d        = 1'b0;
          last_seen_d  = 1'b0;
        end
      end

      S_LOAD: begin
        if (xfer) begin
          // A full memory drops the byte and swallows the rest of the image.
          if (word_count_q == CNT_LIMIT) begin
            err_d   = 1'b1;
            state_d = bus.in_last ? S_DONE : S_DRAIN;
          end else begin
            wdata_d[{byte_idx_q, 3'b000} +: 8] = bus.in_data;
            byte_idx_d  = byte_idx_q + IDX_W'(1);
            last_seen_d = bus.in_last;
            if (byte_idx_q == IDX_LAST || bus.in_last) begin
              state_d = S_WRITE;
            end
          end
        end
      end

      S_WRITE: begin
        waddr_d      = waddr_q + WORD_STEP;
        word_count_d = word_count_q + CNT_W'(1);
        wdata_d      = '0;
        byte_idx_d   = '0;
        state_d      = last_seen_q ? S_DONE : S_LOAD;
      end

      S_DRAIN: begin
        if (xfer && bus.in_last) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake and status strobes are registered decodes of the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      waddr_q      <= BASE_ADDR;
      wdata_q      <= '0;
      word_count_q <= '0;
      byte_idx_q   <= '0;
      err_q        <= 1'b0;
      last_seen_q  <= 1'b0;
      in_ready_q   <= 1'b0;
      write_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      word_count_q <= word_count_d;
      byte_idx_q   <= byte_idx_d;
      err_q        <= err_d;
      last_seen_q  <= last_seen_d;
      in_ready_q   <= (state_d == S_LOAD) || (state_d == S_DRAIN);
      write_en_q   <= (state_d == S_WRITE);
      busy_q       <= (state_d == S_LOAD) || (state_d == S_WRITE) || (state_d == S_DRAIN);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.waddr        = waddr_q;
  assign bus.wdata        = wdata_q;
  assign bus.write_en     = write_en_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err_overflow = err_q;
  assign bus.word_count   = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_prog_loader : scoreboard bench for prog_loader (large and tiny memory)
// Revision 1.0
// ============================================================================
module tb_prog_loader;

  localparam int              XLEN  = 32;
  localparam int              ILEN  = 32;
  localparam int              MAXW0 = 1024;
  localparam int              MAXW1 = 2;
  localparam int              CW0   = $clog2(MAXW0) + 1;
  localparam int              CW1   = $clog2(MAXW1) + 1;
  localparam logic [31:0]     BASE0 = 32'h0000_0000;
  localparam logic [31:0]     BASE1 = 32'h0000_1000;
  localparam int              WAIT_LIMIT = 40;

  localparam int K_RESET = 0;
  localparam int K_START = 1;
  localparam int K_TMO   = 2;
  localparam int K_END   = 3;
  localparam int K_ERR   = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  logic       sel     = 1'b0;
  logic       start_r = 1'b0;
  logic       valid_r = 1'b0;
  logic       last_r  = 1'b0;
  logic [7:0] data_r  = 8'h00;
  logic       rdy;

  prog_loader_if #(.XLEN(XLEN), .ILEN(ILEN), .CNT_W(CW0)) b0 ();
  prog_loader_if #(.XLEN(XLEN), .ILEN(ILEN), .CNT_W(CW1)) b1 ();

  assign b0.start    = start_r & ~sel;
  assign b0.in_valid = valid_r & ~sel;
  assign b0.in_data  = data_r;
  assign b0.in_last  = last_r;
  assign b1.start    = start_r & sel;
  assign b1.in_valid = valid_r & sel;
  assign b1.in_data  = data_r;
  assign b1.in_last  = last_r;
  assign rdy         = sel ? b1.in_ready : b0.in_ready;

  prog_loader #(.XLEN(XLEN), .ILEN(ILEN), .BASE_ADDR(BASE0), .MAX_WORDS(MAXW0), .CNT_W(CW0))
    dut0 (.clock(clock), .reset(reset), .bus(b0.slave));
  prog_loader #(.XLEN(XLEN), .ILEN(ILEN), .BASE_ADDR(BASE1), .MAX_WORDS(MAXW1), .CNT_W(CW1))
    dut1 (.clock(clock), .reset(reset), .bus(b1.slave));

  typedef struct { int unsigned cyc; logic [31:0] addr; logic [31:0] data; } wexp_t;
  typedef struct { int unsigned cyc; logic [31:0] cnt;  logic err; }         dexp_t;
  typedef struct { int unsigned cyc; int id; int kind; logic [31:0] arg; }   sexp_t;

  wexp_t wq [2][$];
  dexp_t dq [2][$];
  sexp_t sq [$];
  int    checks = 0;
  int    errors = 0;

  function automatic void chk(string name, int id, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, id, cyc, act, exp);
    end
  endfunction

  task automatic push_s(int unsigned c, int id, int kind, logic [31:0] arg);
    sexp_t e;
    e.cyc = c; e.id = id; e.kind = kind; e.arg = arg;
    sq.push_back(e);
  endtask

  task automatic mon(input int id, input logic we, input logic rd, input logic bsy,
                     input logic dn, input logic err, input logic [31:0] wa,
                     input logic [31:0] wd, input logic [31:0] wc);
    for (int i = sq.size() - 1; i >= 0; i--) begin
      if (sq[i].id == id && sq[i].cyc == cyc) begin
        case (sq[i].kind)
          K_RESET: begin
            chk("rst_in_ready", id, 32'(rd), 0);
            chk("rst_write_en", id, 32'(we), 0);
            chk("rst_busy", id, 32'(bsy), 0);
            chk("rst_done", id, 32'(dn), 0);
            chk("rst_err", id, 32'(err), 0);
            chk("rst_wdata", id, wd, 0);
            chk("rst_word_count", id, wc, 0);
            chk("rst_waddr", id, wa, sq[i].arg);
          end
          K_START: begin
            chk("start_busy", id, 32'(bsy), 1);
            chk("start_in_ready", id, 32'(rd), 1);
            chk("start_err_cleared", id, 32'(err), 0);
            chk("start_word_count", id, wc, 0);
            chk("start_waddr", id, wa, sq[i].arg);
          end
          K_TMO: chk("ready_wait_cycles", id, sq[i].arg, 0);
          K_END: begin
            chk("pending_writes", id, 32'(wq[id].size()), 0);
            chk("pending_dones", id, 32'(dq[id].size()), 0);
          end
          default: begin
            chk("overflow_err", id, 32'(err), 1);
            chk("overflow_no_write", id, 32'(we), 0);
          end
        endcase
        sq.delete(i);
      end
    end

    if (wq[id].size() > 0 && wq[id][0].cyc == cyc) begin
      chk("write_en", id, 32'(we), 1);
      chk("waddr", id, wa, wq[id][0].addr);
      chk("wdata", id, wd, wq[id][0].data);
      chk("in_ready_on_write", id, 32'(rd), 0);
      void'(wq[id].pop_front());
    end else if (we) begin
      chk("unexpected_write", id, 32'(we), 0);
    end

    if (dq[id].size() > 0 && dq[id][0].cyc == cyc) begin
      chk("done", id, 32'(dn), 1);
      chk("done_word_count", id, wc, dq[id][0].cnt);
      chk("done_err_overflow", id, 32'(err), 32'(dq[id][0].err));
      chk("busy_at_done", id, 32'(bsy), 0);
      void'(dq[id].pop_front());
    end else if (dn) begin
      chk("unexpected_done", id, 32'(dn), 0);
    end
  endtask

  always @(negedge clock) begin
    mon(0, b0.write_en, b0.in_ready, b0.busy, b0.done, b0.err_overflow,
        b0.waddr, b0.wdata, 32'(b0.word_count));
    mon(1, b1.write_en, b1.in_ready, b1.busy, b1.done, b1.err_overflow,
        b1.waddr, b1.wdata, 32'(b1.word_count));
  end

  // Image model: byte j of pk is byte j of the image; words are 4-byte
  // little-endian chunks with missing bytes zero, stored at base + 4*w.
  task automatic run_session(input int id, input logic [95:0] pk, input int n,
                             input bit gaps, input bit starts, input int rst_after);
    logic [31:0]  words [$];
    logic [31:0]  w32;
    logic [31:0]  base;
    int           maxw, nw, waited;
    bit           ovf;
    int unsigned  k, last_k;
    wexp_t        we_e;
    dexp_t        de_e;

    maxw   = (id == 1) ? MAXW1 : MAXW0;
    base   = (id == 1) ? BASE1 : BASE0;
    nw     = (n + 3) / 4;
    ovf    = (nw > maxw);
    last_k = 0;
    for (int w = 0; w < nw; w++) begin
      w32 = '0;
      for (int b = 0; b < 4; b++)
        if (4 * w + b < n) w32 = w32 | (32'(pk[8 * (4 * w + b) +: 8]) << (8 * b));
      words.push_back(w32);
    end

    sel = id[0];
    @(negedge clock);
    push_s(cyc + 1, id, K_START, base);
    start_r = 1'b1;
    @(posedge clock); #1;
    start_r = 1'b0;

    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        valid_r = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          if (starts && $urandom_range(0, 1) == 1) start_r = 1'b1;
          @(posedge clock); #1;
          start_r = 1'b0;
        end
      end
      valid_r = 1'b1;
      data_r  = pk[8 * i +: 8];
      last_r  = (i == n - 1);
      waited  = 0;
      @(negedge clock);
      while (!rdy && waited < WAIT_LIMIT) begin
        waited++;
        @(negedge clock);
      end
      if (!rdy) begin
        push_s(cyc + 1, id, K_TMO, 32'(waited));
        valid_r = 1'b0;
        last_r  = 1'b0;
        repeat (3) @(posedge clock);
        return;
      end
      k = cyc;
      if ((i % 4 == 3 || i == n - 1) && (i / 4) < maxw) begin
        we_e.cyc  = k + 1;
        we_e.addr = base + 32'(4 * (i / 4));
        we_e.data = words[i / 4];
        wq[id].push_back(we_e);
      end
      if (i == 4 * maxw) push_s(k + 1, id, K_ERR, 0);
      last_k = k;
      @(posedge clock); #1;
      if (i == rst_after) begin
        reset   = 1'b1;
        valid_r = 1'b0;
        last_r  = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        push_s(k + 2, 0, K_RESET, BASE0);
        push_s(k + 2, 1, K_RESET, BASE1);
        repeat (3) @(posedge clock);
        #1;
        return;
      end
    end
    valid_r = 1'b0;
    last_r  = 1'b0;

    de_e.cyc = last_k + (ovf ? 1 : 2);
    de_e.cnt = ovf ? 32'(maxw) : 32'(nw);
    de_e.err = ovf;
    dq[id].push_back(de_e);
    repeat (4) @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          id, n;
    logic [95:0] pk;

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    push_s(cyc + 1, 0, K_RESET, BASE0);
    push_s(cyc + 1, 1, K_RESET, BASE1);
    @(negedge clock);

    run_session(0, 96'h0000_0513, 4, 1'b0, 1'b0, -1);
    run_session(0, 96'h0020_0113_0010_0093, 8, 1'b0, 1'b0, -1);
    run_session(0, 96'h2211_DDCC_BBAA, 6, 1'b0, 1'b0, -1);
    run_session(0, 96'h5A, 1, 1'b0, 1'b0, -1);
    run_session(1, 96'h0C0B0A09_08070605_04030201, 12, 1'b0, 1'b0, -1);
    run_session(1, 96'h55_44332211, 5, 1'b0, 1'b0, -1);
    run_session(1, 96'h0908070605_04030201, 9, 1'b0, 1'b0, -1);
    run_session(0, 96'h0020_0113_0010_0093, 8, 1'b1, 1'b1, -1);

    for (int r = 0; r < 12; r++) begin
      id = int'($urandom_range(0, 1));
      n  = int'($urandom_range(1, 12));
      pk = {$urandom(), $urandom(), $urandom()};
      run_session(id, pk, n, 1'b1, 1'b1, -1);
    end

    run_session(0, 96'h0020_0113_0010_0093, 8, 1'b0, 1'b0, 3);
    run_session(0, 96'h0000_0513, 4, 1'b0, 1'b0, -1);

    @(negedge clock);
    push_s(cyc + 1, 0, K_END, 0);
    push_s(cyc + 1, 1, K_END, 0);
    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
